mem_data_arbiter: RTL and testbench
===================================

Name: mem_data_arbiter

Overview:
Two-requester arbiter that shares the unified memory's single data port (load/store port) between the CPU load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1). It round-robin arbitrates when both ports request and issues exactly one single-cycle memory access per grant. It range- and size-checks every request and returns an error instead of accessing memory when the check fails. A timeout watchdog guards against a missing memory acknowledge.

Parameters:
ADDR_WIDTH, 32, address width of requesters and memory port
MEM_SIZE_BYTES, 65536, memory size used for the bounds check
TIMEOUT_CYCLES, 15, maximum WAIT cycles before an error response (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
m0_req  input  1  port 0 request; held with attributes stable until m0_ack
m0_addr  input  ADDR_WIDTH  port 0 byte address
m0_wdata  input  32  port 0 write data (right-justified)
m0_size  input  2  00 byte, 01 halfword, 10 word, 11 invalid
m0_we  input  1  port 0 write enable
m0_rdata  output  32  port 0 read data, valid with m0_ack
m0_ack  output  1  port 0 one-cycle completion pulse
m0_err  output  1  port 0 error flag, valid with m0_ack
m1_req, m1_addr, m1_wdata, m1_size, m1_we, m1_rdata, m1_ack, m1_err  same as port 0, for port 1
mem_req  output  1  to memory data_req
mem_addr  output  ADDR_WIDTH  to memory data_addr
mem_wdata  output  32  to memory data_wdata
mem_size  output  2  to memory data_size
mem_we  output  1  to memory data_we
mem_rdata  input  32  from memory data_rdata
mem_ack  input  1  from memory data_ack (registered, 1 cycle after sampled mem_req)
grant  output  2  one-hot owner, nonzero from ISSUE through RESP
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mN_ack, mN_err, grant, busy = 0. mem_addr, mem_wdata, mem_size, mN_rdata = 0. last_grant = 1, so port 0 wins the first contention. Timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, no request: stay. mem_ack is ignored here, including a stale ack left over after a mid-operation reset.
- IDLE, request present: winner is the only requester; if both request, the port != last_grant. At the edge, latch the winner's addr/wdata/size/we into mem_*, set grant, set last_grant = winner.
- Bounds check, applied in IDLE:
  - byte: addr < MEM_SIZE_BYTES
  - half: addr < MEM_SIZE_BYTES-1
  - word: addr < MEM_SIZE_BYTES-3
  - size 11 always fails
- Check passes: go to ISSUE with mem_req=1.
- Check fails: go directly to RESP with err=1 and rdata=0. Memory is not touched; mem_req stays 0.
- ISSUE (one cycle, mem_req=1): at the edge, mem_req<=0, counter<=0, go to WAIT. mem_req is therefore high exactly one cycle per access.
- WAIT, mem_ack=1: capture mem_rdata into the winner's rdata (0 for writes), err=0, pulse the winner's ack, go to RESP.
- WAIT, mem_ack=0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1, go to RESP with err=1, rdata=0.
- RESP (one cycle): the winner's mN_ack=1 with rdata/err valid; the other port's ack stays 0. At the edge, clear ack/err/grant and go to IDLE.
  - No arbitration happens in RESP, so a requester's still-high req during its ack cycle is not re-granted.
- Latency, request first seen in IDLE at cycle T:
  - good access: ack at T+3, so 4-cycle occupancy; the next grant is decided at T+4
  - bounds error: ack at T+1
  - timeout: ack at T+2+TIMEOUT_CYCLES
- Requester rules: req and attributes stay stable from assertion until the ack cycle. Deasserting req before ack is illegal; the arbiter completes the latched access regardless.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1. Error responses also update last_grant.
- mN_rdata holds its last value between acks; it is only meaningful with ack.
- Reset mid-operation (any state): return to the reset state next cycle. No ack is produced for the aborted access. A memory write already sampled by memory is not undone.
- Requests are not queued; a requester remains pending until granted.

Test Plan:
- Reset, then m0 word write addr 0x100 data 0xDEADBEEF at T -> mem_req high only at T+1 with size 10, we=1; m0_ack=1, m0_err=0 at T+3. Then m0 word read 0x100 -> m0_rdata=0xDEADBEEF at ack.
- m0 and m1 both hold byte reads continuously from reset -> grants 0,1,0,1 alternating, each ack 4 cycles apart; no ack ever on the non-granted port.
- m1 halfword read addr 0xFFFF (MEM_SIZE_BYTES=65536) -> m1_ack at T+1, m1_err=1, m1_rdata=0, mem_req never asserted. Repeat with size 11 at addr 0 -> same error response.
- Memory model suppresses mem_ack, TIMEOUT_CYCLES=15 -> m0_ack with m0_err=1 at T+17, rdata=0; next request is served normally.
- Assert rst during WAIT while memory returns ack next cycle -> no mN_ack, all outputs 0, state IDLE; a new m1 request is then served normally with m0 winning the first tie.
- m0 byte write 0xA5 to 0x10, then halfword read 0x10 by m1 -> m1_rdata=0x0000A5xx, where xx is the prior byte at 0x11, confirming big-endian pass-through.

Source files
------------

// File: rtl/mem_data_arbiter_if.sv
// Bus bundle for mem_data_arbiter: two requester ports, the shared memory
// data port, and arbiter status.
//   m0_*/m1_* : requester request/response signals
//   mem_*     : single-access memory data port
//   grant     : one-hot owner, busy: arbiter not idle
// slave modport is the arbiter side, master modport is the requester/memory side.
interface mem_data_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic [1:0]            m0_size;
  logic                  m0_we;
  logic [31:0]           m0_rdata;
  logic                  m0_ack;
  logic                  m0_err;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic [1:0]            m1_size;
  logic                  m1_we;
  logic [31:0]           m1_rdata;
  logic                  m1_ack;
  logic                  m1_err;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  logic [1:0]            grant;
  logic                  busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_size, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_size, m1_we,
    input  mem_rdata, mem_ack,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output mem_req, mem_addr, mem_wdata, mem_size, mem_we,
    output grant, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_size, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_size, m1_we,
    output mem_rdata, mem_ack,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_req, mem_addr, mem_wdata, mem_size, mem_we,
    input  grant, busy
  );
endinterface

// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter sharing the memory data port between two requesters.
// Each grant issues one single-cycle memory access after a bounds/size check;
// failed checks and missing memory acknowledges return an error response.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_data_arbiter_if.slave (requester ports, memory port, grant/busy)
module mem_data_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_SIZE_BYTES = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_data_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CMP_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_size_q, mem_size_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [1:0][31:0]      rdata_q, rdata_d;
  logic [1:0]            grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Port granted most recently; also identifies the owner while not idle.
  logic                  last_grant_q, last_grant_d;

  logic                  any_req;
  logic                  win;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [1:0]            sel_size;
  logic                  sel_we;
  logic [CMP_W-1:0]      addr_ext;
  logic                  in_range;
  logic                  timeout_hit;

  // Winner: the sole requester, or the port that did not win last time.
  assign any_req   = bus.m0_req | bus.m1_req;
  assign win       = (bus.m0_req & bus.m1_req) ? ~last_grant_q : bus.m1_req;
  assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  assign sel_size  = win ? bus.m1_size  : bus.m0_size;
  assign sel_we    = win ? bus.m1_we    : bus.m0_we;
  assign addr_ext  = CMP_W'(sel_addr);

  // Whole access must fit below MEM_SIZE_BYTES; size 11 is never legal.
  always_comb begin
    case (sel_size)
      2'b00:   in_range = addr_ext < CMP_W'(MEM_SIZE_BYTES);
      2'b01:   in_range = addr_ext < CMP_W'(MEM_SIZE_BYTES - 1);
      2'b10:   in_range = addr_ext < CMP_W'(MEM_SIZE_BYTES - 3);
      default: in_range = 1'b0;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = in_range ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.mem_ack || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath state.
  always_comb begin
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_size_d   = mem_size_q;
    mem_we_d     = mem_we_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // mem_ack is deliberately ignored here (stale ack after reset).
        if (any_req) begin
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          mem_size_d   = sel_size;
          mem_we_d     = sel_we;
          grant_d      = win ? 2'b10 : 2'b01;
          last_grant_d = win;
          if (in_range) begin
            mem_req_d = 1'b1;
          end else begin
            ack_d[win]   = 1'b1;
            err_d[win]   = 1'b1;
            rdata_d[win] = 32'h0;
          end
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (bus.mem_ack) begin
          ack_d[last_grant_q]   = 1'b1;
          rdata_d[last_grant_q] = mem_we_q ? 32'h0 : bus.mem_rdata;
        end else if (timeout_hit) begin
          ack_d[last_grant_q]   = 1'b1;
          err_d[last_grant_q]   = 1'b1;
          rdata_d[last_grant_q] = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  grant_d = 2'b00;
      default: grant_d = 2'b00;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_size_q   <= 2'b00;
      mem_we_q     <= 1'b0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= '0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      mem_we_q     <= mem_we_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.m0_ack    = ack_q[0];
  assign bus.m0_err    = err_q[0];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m1_err    = err_q[1];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed testbench for mem_data_arbiter with a big-endian byte memory model.
module tb_mem_data_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_data_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_data_arbiter #(
    .ADDR_WIDTH(32),
    .MEM_SIZE_BYTES(65536),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1-cycle registered ack, optional extra delay, ack suppression.
  logic [7:0]  mem [0:1023];
  bit          ack_en;
  int unsigned extra_dly;
  int unsigned pend_cnt;
  logic [31:0] p_addr, p_wdata;
  logic [1:0]  p_size;
  logic        p_we;
  logic        use_p, do_acc;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic        a_we;
  logic [9:0]  ai;

  assign use_p   = (pend_cnt == 1);
  assign do_acc  = use_p || (bus.mem_req && ack_en && extra_dly == 0);
  assign a_addr  = use_p ? p_addr  : bus.mem_addr;
  assign a_wdata = use_p ? p_wdata : bus.mem_wdata;
  assign a_size  = use_p ? p_size  : bus.mem_size;
  assign a_we    = use_p ? p_we    : bus.mem_we;
  assign ai      = a_addr[9:0];

  always @(posedge clk) begin
    bus.mem_ack <= do_acc;
    if (rst) mem[17] <= 8'h3C;
    if (bus.mem_req && ack_en && extra_dly != 0) begin
      p_addr   <= bus.mem_addr;
      p_wdata  <= bus.mem_wdata;
      p_size   <= bus.mem_size;
      p_we     <= bus.mem_we;
      pend_cnt <= extra_dly;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
    if (do_acc) begin
      if (a_we) begin
        case (a_size)
          2'b00: mem[ai] <= a_wdata[7:0];
          2'b01: begin
            mem[ai]         <= a_wdata[15:8];
            mem[ai + 10'd1] <= a_wdata[7:0];
          end
          default: begin
            mem[ai]         <= a_wdata[31:24];
            mem[ai + 10'd1] <= a_wdata[23:16];
            mem[ai + 10'd2] <= a_wdata[15:8];
            mem[ai + 10'd3] <= a_wdata[7:0];
          end
        endcase
      end
      case (a_size)
        2'b00:   bus.mem_rdata <= {24'h0, mem[ai]};
        2'b01:   bus.mem_rdata <= {16'h0, mem[ai], mem[ai + 10'd1]};
        default: bus.mem_rdata <= {mem[ai], mem[ai + 10'd1], mem[ai + 10'd2], mem[ai + 10'd3]};
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on one port, starting from an idle cycle; checks latency,
  // response, memory-port activity and grant.
  task automatic do_access(input string tag, input bit port, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input bit we,
                           input int exp_lat, input bit exp_err, input bit chk_rd,
                           input logic [31:0] exp_rd, input int exp_nreq);
    int          lat, nreq, req_k, other;
    logic [31:0] rd;
    logic        er, we1;
    logic [1:0]  sz1, g1;
    lat = -1; nreq = 0; req_k = -1; other = 0;
    rd = 32'h0; er = 1'b0; we1 = 1'b0; sz1 = 2'b00; g1 = 2'b00;
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(bus.busy), 32'h0);
    if (port == 1'b0) begin
      bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_size = size; bus.m0_we = we;
      bus.m0_req = 1'b1;
    end else begin
      bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_size = size; bus.m1_we = we;
      bus.m1_req = 1'b1;
    end
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) g1 = bus.grant;
      if (bus.mem_req) begin
        nreq++;
        if (req_k < 0) req_k = k;
        sz1 = bus.mem_size;
        we1 = bus.mem_we;
      end
      if ((port ? bus.m0_ack : bus.m1_ack) == 1'b1) other++;
      if ((port ? bus.m1_ack : bus.m0_ack) == 1'b1) begin
        lat = k;
        rd  = port ? bus.m1_rdata : bus.m0_rdata;
        er  = port ? bus.m1_err   : bus.m0_err;
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check_eq({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check_eq({tag, "_err"},   32'(er), 32'(exp_err));
    check_eq({tag, "_grant"}, 32'(g1), port ? 32'h2 : 32'h1);
    check_eq({tag, "_other"}, 32'(other), 32'h0);
    check_eq({tag, "_nreq"},  32'(nreq), 32'(exp_nreq));
    if (chk_rd) check_eq({tag, "_rdata"}, rd, exp_rd);
    if (exp_nreq != 0) begin
      check_eq({tag, "_req_k"}, 32'(req_k), 32'h1);
      check_eq({tag, "_size"},  32'(sz1), 32'(size));
      check_eq({tag, "_we"},    32'(we1), 32'(we));
    end
  endtask

  int          ack_k   [4];
  int          ack_p   [4];
  logic [31:0] ack_rd  [4];
  int          n_acks, n_both;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; ack_en = 1'b1; extra_dly = 0;
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_size = '0; bus.m0_we = 1'b0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_size = '0; bus.m1_we = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_mem_req",  32'(bus.mem_req), 32'h0);
    check_eq("rst_grant",    32'(bus.grant), 32'h0);
    check_eq("rst_busy",     32'(bus.busy), 32'h0);
    check_eq("rst_acks",     32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_we",   32'(bus.mem_we), 32'h0);
    check_eq("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check_eq("rst_m1_rdata", bus.m1_rdata, 32'h0);
    rst = 1'b0;

    do_access("wr_word",  1'b0, 32'h100,  32'hDEADBEEF, 2'b10, 1'b1, 3, 1'b0, 1'b1, 32'h0, 1);
    do_access("rd_word",  1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 3, 1'b0, 1'b1, 32'hDEADBEEF, 1);
    do_access("wr_byte",  1'b0, 32'h10,   32'hA5,       2'b00, 1'b1, 3, 1'b0, 1'b1, 32'h0, 1);
    do_access("rd_half",  1'b1, 32'h10,   32'h0,        2'b01, 1'b0, 3, 1'b0, 1'b1, 32'h0000A53C, 1);
    do_access("half_oob", 1'b1, 32'hFFFF, 32'h0,        2'b01, 1'b0, 1, 1'b1, 1'b1, 32'h0, 0);
    do_access("size11",   1'b1, 32'h0,    32'h0,        2'b11, 1'b0, 1, 1'b1, 1'b1, 32'h0, 0);
    do_access("word_top", 1'b0, 32'hFFFC, 32'h0,        2'b10, 1'b0, 3, 1'b0, 1'b0, 32'h0, 1);
    do_access("word_oob", 1'b0, 32'hFFFD, 32'h0,        2'b10, 1'b0, 1, 1'b1, 1'b1, 32'h0, 0);
    do_access("byte_top", 1'b1, 32'hFFFF, 32'h0,        2'b00, 1'b0, 3, 1'b0, 1'b0, 32'h0, 1);

    ack_en = 1'b0;
    do_access("timeout",  1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 17, 1'b1, 1'b1, 32'h0, 1);
    ack_en = 1'b1;
    do_access("after_to", 1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 3, 1'b0, 1'b1, 32'hDEADBEEF, 1);

    // Reset while waiting; memory acks the aborted access one cycle later.
    extra_dly = 1;
    @(negedge clk);
    bus.m0_addr = 32'h100; bus.m0_size = 2'b10; bus.m0_we = 1'b0; bus.m0_req = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_busy", 32'(bus.busy), 32'h1);
    check_eq("mid_noack", 32'(bus.mem_ack), 32'h0);
    rst = 1'b1; bus.m0_req = 1'b0;
    @(negedge clk);
    check_eq("mid_stale_ack", 32'(bus.mem_ack), 32'h1);
    check_eq("mid_rst_outs", 32'({bus.m0_ack, bus.m1_ack, bus.busy, bus.grant, bus.mem_req}), 32'h0);
    check_eq("mid_rst_rdata", bus.m0_rdata, 32'h0);
    rst = 1'b0; extra_dly = 0;

    // Both ports request continuously: grants alternate, port 0 first.
    bus.m0_addr = 32'h10; bus.m0_size = 2'b00; bus.m0_we = 1'b0; bus.m0_req = 1'b1;
    bus.m1_addr = 32'h11; bus.m1_size = 2'b00; bus.m1_we = 1'b0; bus.m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin ack_k[i] = -1; ack_p[i] = -1; ack_rd[i] = 32'h0; end
    n_acks = 0; n_both = 0;
    for (int k = 1; k <= 24 && n_acks < 4; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("fair_first_grant", 32'(bus.grant), 32'h1);
      if (bus.m0_ack && bus.m1_ack) n_both++;
      else if (bus.m0_ack || bus.m1_ack) begin
        ack_k[n_acks]  = k;
        ack_p[n_acks]  = bus.m1_ack ? 1 : 0;
        ack_rd[n_acks] = bus.m1_ack ? bus.m1_rdata : bus.m0_rdata;
        n_acks++;
      end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    check_eq("fair_both", 32'(n_both), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fair%0d_k", i),    32'(ack_k[i]), 32'(3 + 4 * i));
      check_eq($sformatf("fair%0d_port", i), 32'(ack_p[i]), 32'(i % 2));
      check_eq($sformatf("fair%0d_rd", i),   ack_rd[i], (i % 2 == 0) ? 32'hA5 : 32'h3C);
    end

    do_access("m1_after", 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 3, 1'b0, 1'b1, 32'hA5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
